handle_move_multi: RTL and testbench

//  Next-generation move handler for one player's turn. Picks up a run of 1..MAX_SEL adjacent cards by successive

---
 rtl/handle_move_multi_pkg.sv | 25 ++
 rtl/handle_move_multi_ack_timer.sv | 29 ++
 rtl/handle_move_multi.sv | 216 +++++++++++++++++++++
 tb/tb_handle_move_multi.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handle_move_multi_pkg.sv
// Shared codes for the move handler: game turn states, interboard message types, FSM encoding.
package handle_move_multi_pkg;

    localparam logic [3:0] GS_P0_TURN = 4'd1;
    localparam logic [3:0] GS_P1_TURN = 4'd2;

    localparam logic [3:0] MSG_MOVE_TAKE    = 4'd1;
    localparam logic [3:0] MSG_MOVE_DOWN    = 4'd2;
    localparam logic [3:0] MSG_MOVE_RESTORE = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HOLD     = 3'd4,
        ST_DONE     = 3'd5
    } move_state_t;

    // Game state code meaning "it is this player's turn".
    function automatic logic [3:0] turn_state(input int player);
        return (player == 0) ? GS_P0_TURN : GS_P1_TURN;
    endfunction

endpackage

// File: rtl/handle_move_multi_ack_timer.sv
// Acknowledge watchdog: loaded while a request is pulsed, counts down while waiting,
// flags expiry once ACK_TIMEOUT waiting cycles have passed without an acknowledge.
module handle_move_multi_ack_timer #(
    parameter  int ACK_TIMEOUT = 1023,
    localparam int CNT_W       = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic run,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    // Down-counter with terminal count at zero; start has priority over counting.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(ACK_TIMEOUT - 1);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/handle_move_multi.sv
// Multi-card move handler for one player's turn: builds a run of adjacent cards,
// then drops or restores it, issuing each step as an acknowledged request.
//
//   state    | meaning
//   IDLE     | waiting for move_en on my turn
//   SELECT   | move open, nothing picked up yet
//   REQ      | request pulse to the interboard controller
//   WAIT_ACK | waiting for inter_ready (re-pulses on timeout)
//   HOLD     | run in hand; extend, drop or restore
//   DONE     | move_done pulse, back to IDLE
module handle_move_multi
    import handle_move_multi_pkg::*;
#(
    parameter  int PLAYER      = 0,
    parameter  int BX_W        = 5,
    parameter  int BY_W        = 3,
    parameter  int CARD_W      = 6,
    parameter  int MAX_SEL     = 7,
    parameter  int ACK_TIMEOUT = 1023,
    localparam int SEL_W       = $clog2(MAX_SEL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interboard_rst,
    input  logic              move_en,
    input  logic [3:0]        cur_game_state,
    input  logic              inter_ready,
    input  logic              valid_card_take,
    input  logic              valid_card_down,
    input  logic [CARD_W-1:0] hover_card,
    input  logic              l_click,
    input  logic              r_click,
    input  logic              mouse_inblock,
    input  logic [BX_W-1:0]   mouse_block_x,
    input  logic [BY_W-1:0]   mouse_block_y,
    output logic              move_done,
    output logic              move_ctrl_en,
    output logic              move_ctrl_move_dir,
    output logic [BX_W-1:0]   move_ctrl_block_x,
    output logic [BY_W-1:0]   move_ctrl_block_y,
    output logic [3:0]        move_ctrl_msg_type,
    output logic [CARD_W-1:0] move_ctrl_card,
    output logic [SEL_W-1:0]  move_ctrl_sel_len,
    output logic              busy
);

    move_state_t state_q, state_d;

    logic              rst_all;
    logic              my_turn;
    logic              listening;
    logic              l_q, r_q, inblock_q, take_q, down_q;
    logic [BX_W-1:0]   x_q, origin_x, last_x;
    logic [BY_W-1:0]   y_q, origin_y;
    logic [CARD_W-1:0] card_q, first_card;
    logic [SEL_W-1:0]  sel_len;
    logic              take_ok, down_ok, can_extend, expire;
    logic              do_first, do_extend, do_down, do_restore;

    assign rst_all   = rst | interboard_rst;
    assign my_turn   = (cur_game_state == turn_state(PLAYER));
    // Clicks only count while the FSM is actually looking at them.
    assign listening = (state_q == ST_SELECT) || (state_q == ST_HOLD);

    assign take_ok    = l_q & inblock_q & take_q;
    assign down_ok    = l_q & inblock_q & down_q;
    // Run grows rightwards along the origin row; no wrap past the last column.
    assign can_extend = (y_q == origin_y) && (last_x != '1) &&
                        (x_q == last_x + 1'b1) && (sel_len < SEL_W'(MAX_SEL));

    // Input capture stage: one registered copy of the mouse/click view.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            l_q       <= 1'b0;
            r_q       <= 1'b0;
            inblock_q <= 1'b0;
            take_q    <= 1'b0;
            down_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            card_q    <= '0;
        end else begin
            l_q       <= l_click & listening;
            r_q       <= r_click & listening;
            inblock_q <= mouse_inblock;
            take_q    <= valid_card_take;
            down_q    <= valid_card_down;
            x_q       <= mouse_block_x;
            y_q       <= mouse_block_y;
            card_q    <= hover_card;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_all) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode; right click (or losing the turn) beats any left click.
    always_comb begin
        state_d    = state_q;
        do_first   = 1'b0;
        do_extend  = 1'b0;
        do_down    = 1'b0;
        do_restore = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (move_en && my_turn) state_d = ST_SELECT;
            end
            ST_SELECT, ST_HOLD: begin
                if (!my_turn || r_q) begin
                    if (sel_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        do_restore = 1'b1;
                        state_d    = ST_REQ;
                    end
                end else if (take_ok && (sel_len == '0)) begin
                    do_first = 1'b1;
                    state_d  = ST_REQ;
                end else if (take_ok && can_extend) begin
                    do_extend = 1'b1;
                    state_d   = ST_REQ;
                end else if (down_ok && (state_q == ST_HOLD)) begin
                    do_down = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (inter_ready)
                    state_d = (move_ctrl_msg_type == MSG_MOVE_TAKE) ? ST_HOLD : ST_DONE;
                else if (expire)
                    state_d = ST_REQ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run bookkeeping and request fields; fields stay put until the next queued request.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            origin_x           <= '0;
            origin_y           <= '0;
            last_x             <= '0;
            first_card         <= '0;
            sel_len            <= '0;
            move_ctrl_move_dir <= 1'b0;
            move_ctrl_block_x  <= '0;
            move_ctrl_block_y  <= '0;
            move_ctrl_msg_type <= '0;
            move_ctrl_card     <= '0;
            move_ctrl_sel_len  <= '0;
        end else if (do_first) begin
            origin_x           <= x_q;
            origin_y           <= y_q;
            last_x             <= x_q;
            first_card         <= card_q;
            sel_len            <= SEL_W'(1);
            move_ctrl_move_dir <= 1'b0;
            move_ctrl_block_x  <= x_q;
            move_ctrl_block_y  <= y_q;
            move_ctrl_msg_type <= MSG_MOVE_TAKE;
            move_ctrl_card     <= card_q;
            move_ctrl_sel_len  <= SEL_W'(1);
        end else if (do_extend) begin
            last_x             <= x_q;
            sel_len            <= sel_len + 1'b1;
            move_ctrl_move_dir <= 1'b0;
            move_ctrl_block_x  <= x_q;
            move_ctrl_block_y  <= y_q;
            move_ctrl_msg_type <= MSG_MOVE_TAKE;
            move_ctrl_card     <= card_q;
            move_ctrl_sel_len  <= sel_len + 1'b1;
        end else if (do_down) begin
            move_ctrl_move_dir <= 1'b1;
            move_ctrl_block_x  <= x_q;
            move_ctrl_block_y  <= y_q;
            move_ctrl_msg_type <= MSG_MOVE_DOWN;
            move_ctrl_card     <= first_card;
            move_ctrl_sel_len  <= sel_len;
        end else if (do_restore) begin
            move_ctrl_move_dir <= 1'b1;
            move_ctrl_block_x  <= origin_x;
            move_ctrl_block_y  <= origin_y;
            move_ctrl_msg_type <= MSG_MOVE_RESTORE;
            move_ctrl_card     <= first_card;
            move_ctrl_sel_len  <= sel_len;
        end else if (state_q == ST_DONE) begin
            sel_len <= '0;
        end
    end

    handle_move_multi_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk   (clk),
        .clear (rst_all),
        .start (state_q == ST_REQ),
        .run   (state_q == ST_WAIT_ACK),
        .expire(expire)
    );

    assign move_ctrl_en = (state_q == ST_REQ);
    assign move_done    = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_handle_move_multi.sv
// Bench for handle_move_multi: table of click steps with a request scoreboard,
// plus hand sequences for timeout, resets and turn changes.
module tb_handle_move_multi;
    import handle_move_multi_pkg::*;

    localparam int BX_W        = 5;
    localparam int BY_W        = 3;
    localparam int CARD_W      = 6;
    localparam int MAX_SEL     = 3;
    localparam int ACK_TIMEOUT = 15;
    localparam int SEL_W       = 2;

    logic              clk = 1'b0;
    logic              rst, interboard_rst, move_en, inter_ready;
    logic [3:0]        cur_game_state;
    logic              valid_card_take, valid_card_down, l_click, r_click, mouse_inblock;
    logic [CARD_W-1:0] hover_card;
    logic [BX_W-1:0]   mouse_block_x;
    logic [BY_W-1:0]   mouse_block_y;
    logic              move_done, move_ctrl_en, move_ctrl_move_dir, busy;
    logic [BX_W-1:0]   move_ctrl_block_x;
    logic [BY_W-1:0]   move_ctrl_block_y;
    logic [3:0]        move_ctrl_msg_type;
    logic [CARD_W-1:0] move_ctrl_card;
    logic [SEL_W-1:0]  move_ctrl_sel_len;

    typedef struct packed {
        logic              dir;
        logic [BX_W-1:0]   x;
        logic [BY_W-1:0]   y;
        logic [3:0]        msg;
        logic [CARD_W-1:0] card;
        logic [SEL_W-1:0]  len;
    } req_t;

    typedef struct {
        bit                start;
        bit                l, r, inb, vt, vd;
        logic [BX_W-1:0]   x;
        logic [BY_W-1:0]   y;
        logic [CARD_W-1:0] card;
        bit                exp_req;
        req_t              req;
        bit                exp_done;
    } step_t;

    int     tests = 0;
    int     fails = 0;
    int     en_cnt = 0;
    int     base, gap;
    req_t   exp_q[$];
    req_t   act, e_mon;
    step_t  steps[$];
    step_t  s;
    logic [23:0] all_out;

    handle_move_multi #(
        .PLAYER(0), .BX_W(BX_W), .BY_W(BY_W), .CARD_W(CARD_W),
        .MAX_SEL(MAX_SEL), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .move_en(move_en),
        .cur_game_state(cur_game_state), .inter_ready(inter_ready),
        .valid_card_take(valid_card_take), .valid_card_down(valid_card_down),
        .hover_card(hover_card), .l_click(l_click), .r_click(r_click),
        .mouse_inblock(mouse_inblock), .mouse_block_x(mouse_block_x),
        .mouse_block_y(mouse_block_y), .move_done(move_done), .move_ctrl_en(move_ctrl_en),
        .move_ctrl_move_dir(move_ctrl_move_dir), .move_ctrl_block_x(move_ctrl_block_x),
        .move_ctrl_block_y(move_ctrl_block_y), .move_ctrl_msg_type(move_ctrl_msg_type),
        .move_ctrl_card(move_ctrl_card), .move_ctrl_sel_len(move_ctrl_sel_len), .busy(busy)
    );

    always #5 clk = ~clk;

    assign act = {move_ctrl_move_dir, move_ctrl_block_x, move_ctrl_block_y,
                  move_ctrl_msg_type, move_ctrl_card, move_ctrl_sel_len};
    assign all_out = {move_done, move_ctrl_en, move_ctrl_move_dir, move_ctrl_block_x,
                      move_ctrl_block_y, move_ctrl_msg_type, move_ctrl_card,
                      move_ctrl_sel_len, busy};

    // Scoreboard: every request pulse must match the oldest expected request.
    always @(negedge clk) begin
        if (move_ctrl_en) begin
            en_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL req_unexpected: got %h, required no request", act);
            end else begin
                e_mon = exp_q.pop_front();
                if (act !== e_mon) begin
                    fails++;
                    $display("FAIL req_fields: got %h, required %h", act, e_mon);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic req_t mkreq(input logic dir, input int x, input int y,
                                   input logic [3:0] msg, input int card, input int len);
        req_t r;
        r.dir  = dir;
        r.x    = BX_W'(x);
        r.y    = BY_W'(y);
        r.msg  = msg;
        r.card = CARD_W'(card);
        r.len  = SEL_W'(len);
        return r;
    endfunction

    function automatic step_t row_start();
        step_t t;
        t.start = 1'b1; t.l = 1'b0; t.r = 1'b0; t.inb = 1'b0; t.vt = 1'b0; t.vd = 1'b0;
        t.x = '0; t.y = '0; t.card = '0; t.exp_req = 1'b0; t.req = '0; t.exp_done = 1'b0;
        return t;
    endfunction

    function automatic step_t row_click(input bit l, input bit r, input bit inb, input bit vt,
                                        input bit vd, input int x, input int y, input int card,
                                        input bit exp_done);
        step_t t = row_start();
        t.start = 1'b0; t.l = l; t.r = r; t.inb = inb; t.vt = vt; t.vd = vd;
        t.x = BX_W'(x); t.y = BY_W'(y); t.card = CARD_W'(card); t.exp_done = exp_done;
        return t;
    endfunction

    function automatic step_t row_req(input bit l, input bit r, input bit inb, input bit vt,
                                      input bit vd, input int x, input int y, input int card,
                                      input req_t rq, input bit exp_done);
        step_t t = row_click(l, r, inb, vt, vd, x, y, card, exp_done);
        t.exp_req = 1'b1;
        t.req     = rq;
        return t;
    endfunction

    task automatic click(input bit l, input bit r, input bit inb, input bit vt, input bit vd,
                         input logic [BX_W-1:0] x, input logic [BY_W-1:0] y,
                         input logic [CARD_W-1:0] card);
        l_click = l; r_click = r; mouse_inblock = inb;
        valid_card_take = vt; valid_card_down = vd;
        mouse_block_x = x; mouse_block_y = y; hover_card = card;
        tick();
        l_click = 1'b0; r_click = 1'b0;
    endtask

    task automatic start_move();
        move_en = 1'b1;
        tick();
        move_en = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (!move_ctrl_en && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (!move_ctrl_en) begin
            fails++;
            $display("FAIL %s: no request pulse within 40 cycles, required one", name);
        end
    endtask

    task automatic ack();
        tick();
        inter_ready = 1'b1;
        tick();
        inter_ready = 1'b0;
    endtask

    task automatic check_done(input string name);
        chk({name, "_done_pulse"}, 64'(move_done), 64'(1));
        tick();
        chk({name, "_done_idle"}, 64'({move_done, busy}), 64'(0));
    endtask

    initial begin
        rst = 1'b1; interboard_rst = 1'b0; move_en = 1'b0; inter_ready = 1'b0;
        cur_game_state = GS_P0_TURN;
        valid_card_take = 1'b0; valid_card_down = 1'b0; hover_card = '0;
        l_click = 1'b0; r_click = 1'b0; mouse_inblock = 1'b0;
        mouse_block_x = '0; mouse_block_y = '0;

        // single move
        steps.push_back(row_start());
        steps.push_back(row_req(1,0,1,1,0, 3,2,'h15, mkreq(0,3,2,MSG_MOVE_TAKE,'h15,1), 0));
        steps.push_back(row_req(1,0,1,0,1, 7,4,'h00, mkreq(1,7,4,MSG_MOVE_DOWN,'h15,1), 1));
        // run of three, full run and off-run clicks ignored
        steps.push_back(row_start());
        steps.push_back(row_req(1,0,1,1,0, 3,2,'h21, mkreq(0,3,2,MSG_MOVE_TAKE,'h21,1), 0));
        steps.push_back(row_req(1,0,1,1,0, 4,2,'h22, mkreq(0,4,2,MSG_MOVE_TAKE,'h22,2), 0));
        steps.push_back(row_req(1,0,1,1,0, 5,2,'h23, mkreq(0,5,2,MSG_MOVE_TAKE,'h23,3), 0));
        steps.push_back(row_click(1,0,1,1,0, 6,2,'h24, 0));
        steps.push_back(row_click(1,0,1,1,0, 7,2,'h25, 0));
        steps.push_back(row_req(1,0,1,0,1, 0,5,'h00, mkreq(1,0,5,MSG_MOVE_DOWN,'h21,3), 1));
        // cancel with simultaneous left+right click
        steps.push_back(row_start());
        steps.push_back(row_req(1,0,1,1,0, 10,1,'h30, mkreq(0,10,1,MSG_MOVE_TAKE,'h30,1), 0));
        steps.push_back(row_click(1,0,1,1,0, 11,2,'h31, 0));
        steps.push_back(row_req(1,0,1,1,0, 11,1,'h31, mkreq(0,11,1,MSG_MOVE_TAKE,'h31,2), 0));
        steps.push_back(row_req(1,1,1,0,1, 20,6,'h00, mkreq(1,10,1,MSG_MOVE_RESTORE,'h30,2), 1));
        // last column: no wrap; click outside a block ignored
        steps.push_back(row_start());
        steps.push_back(row_req(1,0,1,1,0, 31,3,'h3f, mkreq(0,31,3,MSG_MOVE_TAKE,'h3f,1), 0));
        steps.push_back(row_click(1,0,1,1,0, 0,3,'h01, 0));
        steps.push_back(row_click(1,0,0,0,1, 2,2,'h00, 0));
        steps.push_back(row_req(0,1,0,0,0, 0,0,'h00, mkreq(1,31,3,MSG_MOVE_RESTORE,'h3f,1), 1));
        // empty move
        steps.push_back(row_start());
        steps.push_back(row_click(1,0,0,1,0, 1,1,'h02, 0));
        steps.push_back(row_click(0,1,0,0,0, 0,0,'h00, 1));

        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outputs", 64'(all_out), 64'(0));

        cur_game_state = GS_P1_TURN;
        move_en = 1'b1;
        tick();
        move_en = 1'b0;
        chk("not_my_turn_idle", 64'(busy), 64'(0));
        cur_game_state = GS_P0_TURN;

        foreach (steps[i]) begin
            s = steps[i];
            if (s.start) begin
                start_move();
            end else begin
                base = en_cnt;
                if (s.exp_req) exp_q.push_back(s.req);
                click(s.l, s.r, s.inb, s.vt, s.vd, s.x, s.y, s.card);
                if (s.exp_req) begin
                    wait_en($sformatf("row%0d_req", i));
                    ack();
                end else if (s.exp_done) begin
                    tick();
                end else begin
                    repeat (4) tick();
                    chk($sformatf("row%0d_ignored", i), 64'(en_cnt - base), 64'(0));
                end
                if (s.exp_done) check_done($sformatf("row%0d", i));
            end
        end

        // ack timeout: identical request re-issued after ACK_TIMEOUT waiting cycles
        start_move();
        exp_q.push_back(mkreq(0,4,6,MSG_MOVE_TAKE,'h11,1));
        exp_q.push_back(mkreq(0,4,6,MSG_MOVE_TAKE,'h11,1));
        click(1,0,1,1,0, 5'd4, 3'd6, 6'h11);
        wait_en("timeout_first");
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!move_ctrl_en && gap < 100);
        chk("timeout_gap", 64'(gap), 64'(ACK_TIMEOUT + 1));
        ack();
        chk("timeout_hold_busy", 64'({busy, move_done}), 64'(2));
        exp_q.push_back(mkreq(1,4,6,MSG_MOVE_RESTORE,'h11,1));
        click(0,1,0,0,0, 5'd0, 3'd0, 6'h00);
        wait_en("timeout_restore");
        ack();
        check_done("timeout");

        // rst, then interboard_rst, while waiting for an ack
        for (int k = 0; k < 2; k++) begin
            start_move();
            exp_q.push_back(mkreq(0,2,1,MSG_MOVE_TAKE,'h07,1));
            click(1,0,1,1,0, 5'd2, 3'd1, 6'h07);
            wait_en($sformatf("reset%0d_req", k));
            tick();
            if (k == 0) rst = 1'b1;
            else        interboard_rst = 1'b1;
            tick();
            rst = 1'b0;
            interboard_rst = 1'b0;
            chk($sformatf("reset%0d_outputs", k), 64'(all_out), 64'(0));
        end

        // turn change while waiting for an ack is deferred, then forces a restore
        start_move();
        exp_q.push_back(mkreq(0,8,0,MSG_MOVE_TAKE,'h05,1));
        click(1,0,1,1,0, 5'd8, 3'd0, 6'h05);
        wait_en("defer_take");
        tick();
        cur_game_state = GS_P1_TURN;
        base = en_cnt;
        repeat (3) tick();
        chk("defer_no_req", 64'(en_cnt - base), 64'(0));
        chk("defer_busy", 64'(busy), 64'(1));
        exp_q.push_back(mkreq(1,8,0,MSG_MOVE_RESTORE,'h05,1));
        inter_ready = 1'b1;
        tick();
        inter_ready = 1'b0;
        wait_en("forced_restore");
        ack();
        check_done("forced_restore");
        cur_game_state = GS_P0_TURN;

        // turn lost with nothing picked up: empty completion
        start_move();
        cur_game_state = GS_P1_TURN;
        tick();
        check_done("turn_lost_empty");
        cur_game_state = GS_P0_TURN;

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
